// File: rtl/servo_telemetry_uart_tx_pkg.sv
// Shared definitions for the servo UART link: sync byte, TX frame FSM states, baud math.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package servo_telemetry_uart_tx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SEND_BYTE = 2'd2,
        DONE      = 2'd3
    } tx_state_t;

    // Clocks per serial bit; the receiver derives its sampling from the same value.
    function automatic int baud_tick(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Frame checksum: XOR of the three payload-carrying bytes.
    function automatic logic [7:0] frame_chk(input logic [7:0] sync_byte,
                                             input logic [7:0] x_pos,
                                             input logic [7:0] y_pos);
        return sync_byte ^ x_pos ^ y_pos;
    endfunction

endpackage

// File: rtl/servo_telemetry_uart_tx_byte.sv
// 8N1 byte serializer, LSB first; each bit held BAUD_TICK clocks.
// Latency: uart_tx drops to the start bit on the edge that samples byte_load.
// Backpressure: byte_load is taken only when idle or during the final stop-bit clock (byte_done),
//   which lets the caller chain bytes with no idle gap; loads at other times are ignored.
// Ports: clk50mhz/rst_n (sync, active-low); byte_load + byte_dat in; uart_tx line,
//   tx_busy (byte in flight), byte_done (high during the last clock of the stop bit).
module servo_telemetry_uart_tx_byte #(
    parameter int BAUD_TICK = 5208
) (
    input  logic       clk50mhz,
    input  logic       rst_n,
    input  logic       byte_load,
    input  logic [7:0] byte_dat,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       byte_done
);

    localparam int CNT_W = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(BAUD_TICK - 1);

    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end   = (baud_cnt == TICK_LAST);
    assign byte_done = tx_busy && bit_end && (bit_idx == 4'd9);

    always_ff @(posedge clk50mhz) begin
        if (!rst_n) begin
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (byte_load && (!tx_busy || byte_done)) begin
            uart_tx  <= 1'b0;
            tx_busy  <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= byte_dat;
        end else if (tx_busy) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    tx_busy <= 1'b0;
                    uart_tx <= 1'b1;
                    bit_idx <= '0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd8) begin
                        uart_tx <= 1'b1;  // stop bit
                    end else begin
                        uart_tx <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end
                end
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/servo_telemetry_uart_tx.sv
// Servo telemetry TX: sends {SYNC, X, Y, SYNC^X^Y} as four back-to-back 8N1 bytes on request or periodically.
// Latency: start bit begins 2 edges after the trigger is sampled; frame lasts 40*BAUD_TICK clocks.
// Backpressure: triggers during a frame collapse into one pending frame sent right after the current one.
// Ports: clk50mhz/rst_n (sync, active-low); x_position/y_position snapshotted in LOAD; report_req pulse,
//   report_en level; uart_tx line, busy (LOAD..DONE), frame_done (one cycle after the last stop bit).
module servo_telemetry_uart_tx
    import servo_telemetry_uart_tx_pkg::*;
#(
    parameter int         CLK_FREQ      = 50000000,
    parameter int         BAUD_RATE     = 9600,
    parameter int         REPORT_PERIOD = 5000000,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic       clk50mhz,
    input  logic       rst_n,
    input  logic [7:0] x_position,
    input  logic [7:0] y_position,
    input  logic       report_req,
    input  logic       report_en,
    output logic       uart_tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int BAUD_TICK = baud_tick(CLK_FREQ, BAUD_RATE);
    localparam int TMR_W     = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REPORT_PERIOD - 1);

    tx_state_t        state;
    logic             pending;
    logic [TMR_W-1:0] period_tmr;
    logic [1:0]       byte_idx;
    logic [7:0]       x_q;
    logic [7:0]       y_q;
    logic [7:0]       chk_q;
    logic             first_load;
    logic             period_hit;
    logic             trigger;
    logic             ser_busy;
    logic             byte_done;
    logic             byte_load;
    logic [1:0]       next_idx;
    logic [7:0]       byte_dat;

    assign period_hit = report_en && (period_tmr == TMR_LAST);
    assign trigger    = report_req || period_hit;

    // Timer only runs while auto-reporting is enabled; disabling restarts the period.
    always_ff @(posedge clk50mhz) begin
        if (!rst_n || !report_en) begin
            period_tmr <= '0;
        end else if (period_tmr == TMR_LAST) begin
            period_tmr <= '0;
        end else begin
            period_tmr <= period_tmr + TMR_W'(1);
        end
    end

    // The first byte is launched from a registered strobe one cycle after the snapshot;
    // later bytes are handed over in the final stop-bit clock so there is no idle gap.
    assign next_idx  = first_load ? 2'd0 : (byte_idx + 2'd1);
    assign byte_load = (first_load && !ser_busy) ||
                       ((state == SEND_BYTE) && byte_done && (byte_idx != 2'd3));

    always_comb begin
        byte_dat = SYNC_BYTE;
        case (next_idx)
            2'd0:    byte_dat = SYNC_BYTE;
            2'd1:    byte_dat = x_q;
            2'd2:    byte_dat = y_q;
            default: byte_dat = chk_q;
        endcase
    end

    always_ff @(posedge clk50mhz) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= 1'b0;
            byte_idx   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            chk_q      <= '0;
            first_load <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            first_load <= 1'b0;
            frame_done <= 1'b0;
            // Any trigger outside IDLE, including the DONE cycle, is remembered once.
            if (trigger && (state != IDLE)) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trigger || pending) begin
                        state   <= LOAD;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    x_q        <= x_position;
                    y_q        <= y_position;
                    chk_q      <= frame_chk(SYNC_BYTE, x_position, y_position);
                    byte_idx   <= '0;
                    first_load <= 1'b1;
                    state      <= SEND_BYTE;
                end
                SEND_BYTE: begin
                    if (byte_done) begin
                        if (byte_idx == 2'd3) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    servo_telemetry_uart_tx_byte #(
        .BAUD_TICK (BAUD_TICK)
    ) u_byte (
        .clk50mhz  (clk50mhz),
        .rst_n     (rst_n),
        .byte_load (byte_load),
        .byte_dat  (byte_dat),
        .uart_tx   (uart_tx),
        .tx_busy   (ser_busy),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_servo_telemetry_uart_tx.sv
// Bench for servo_telemetry_uart_tx: expected frames are queued at stimulus time and a
// line monitor decodes the serial output and compares each received frame in order.
module tb_servo_telemetry_uart_tx;

    localparam int CLK_FREQ      = 1000;
    localparam int BAUD_RATE     = 100;
    localparam int TICK          = CLK_FREQ / BAUD_RATE;
    localparam int REPORT_PERIOD = 1000;
    localparam int FRAME_BUSY    = 40 * TICK + 3;  // LOAD + 1 setup cycle + 40 bits + DONE

    logic       clk50mhz;
    logic       rst_n;
    logic [7:0] x_position;
    logic [7:0] y_position;
    logic       report_req;
    logic       report_en;
    logic       uart_tx;
    logic       busy;
    logic       frame_done;

    int checks;
    int failures;
    int cyc;
    int fd_total;
    int frames_pushed;
    int mon_nb;
    logic [31:0] exp_q[$];
    int rise_q[$];
    int fall_q[$];

    servo_telemetry_uart_tx #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD_RATE     (BAUD_RATE),
        .REPORT_PERIOD (REPORT_PERIOD),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk50mhz   (clk50mhz),
        .rst_n      (rst_n),
        .x_position (x_position),
        .y_position (y_position),
        .report_req (report_req),
        .report_en  (report_en),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk50mhz = 1'b0;
    always #5 clk50mhz = ~clk50mhz;

    initial cyc = 0;
    always @(posedge clk50mhz) cyc <= cyc + 1;

    // Reference: the frame the host should see for a given snapshot.
    function automatic logic [31:0] ref_frame(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] s;
        s = 8'hA5;
        return {s, x, y, s ^ x ^ y};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] x, input logic [7:0] y);
        exp_q.push_back(ref_frame(x, y));
        frames_pushed++;
    endtask

    task automatic pulse_req();
        @(posedge clk50mhz);
        #1 report_req = 1'b1;
        @(posedge clk50mhz);
        #1 report_req = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk50mhz);
            n++;
        end
        check(name, busy, lvl);
    endtask

    // Line monitor: decode bytes, check start/stop/bit widths/start latency, score frames.
    initial begin : monitor
        logic        pb;
        logic        ptx;
        logic        mact;
        int          fdrun;
        int          lat;
        int          run;
        int          mcnt;
        int          b;
        logic [7:0]  sh;
        logic [31:0] fr;
        logic [31:0] ex;
        pb = 0; ptx = 1; mact = 0; fdrun = 0; lat = -1; run = 0; mcnt = 0; sh = 0; fr = 0;
        forever begin
            @(negedge clk50mhz);
            if (!rst_n) begin
                pb = 0; ptx = 1; mact = 0; fdrun = 0; lat = -1; run = 0; mcnt = 0; mon_nb = 0;
            end else begin
                if (busy && !pb) begin
                    rise_q.push_back(cyc);
                    lat = 0;
                end else if (lat >= 0) begin
                    lat++;
                end
                if (!busy && pb) fall_q.push_back(cyc);
                pb = busy;
                if (lat >= 0 && !uart_tx) begin
                    check("start_latency", lat, 2);
                    lat = -1;
                end

                if (frame_done) begin
                    fdrun++;
                end else if (fdrun > 0) begin
                    check("frame_done_width", fdrun, 1);
                    fd_total++;
                    fdrun = 0;
                end

                if (uart_tx !== ptx) begin
                    if (!ptx || mact) check("bit_run_len", run % TICK, 0);
                    run = 1;
                end else begin
                    run++;
                end
                ptx = uart_tx;

                if (!mact) begin
                    if (!uart_tx) begin
                        mact = 1;
                        mcnt = 0;
                    end
                end else begin
                    mcnt++;
                end
                if (mact && (mcnt % TICK == TICK / 2)) begin
                    b = mcnt / TICK;
                    if (b == 0) begin
                        check("start_bit", uart_tx, 0);
                    end else if (b <= 8) begin
                        sh[b-1] = uart_tx;
                    end else begin
                        check("stop_bit", uart_tx, 1);
                        mact = 0;
                        fr = {fr[23:0], sh};
                        mon_nb++;
                        if (mon_nb == 4) begin
                            mon_nb = 0;
                            if (exp_q.size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_frame: got %h, expected no frame", fr);
                            end else begin
                                ex = exp_q.pop_front();
                                check("frame_data", fr, ex);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (100000) @(posedge clk50mhz);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int n0;
        int en_cyc;
        int fd0;
        int lows;
        logic [7:0] xr;
        logic [7:0] yr;
        checks = 0; failures = 0; fd_total = 0; frames_pushed = 0; mon_nb = 0;
        rst_n = 0; report_req = 0; report_en = 0; x_position = 0; y_position = 0;
        repeat (3) @(posedge clk50mhz);
        #1;
        check("reset_uart_tx", uart_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        rst_n = 1;

        // 1: basic frame A5,80,40,65
        x_position = 8'h80; y_position = 8'h40;
        expect_frame(8'h80, 8'h40);
        pulse_req();
        n = 0;
        while (uart_tx && n < 50) begin
            @(posedge clk50mhz);
            #1 n++;
        end
        check("t1_start_edges", n, 2);
        wait_busy(0, 1000, "t1_busy_fall");
        check("t1_busy_cycles", fall_q[$] - rise_q[$], FRAME_BUSY);
        repeat (5) @(posedge clk50mhz);
        check("t1_frame_done_count", fd_total, 1);

        // 2: two requests during a frame merge into one extra frame
        xr = 8'($urandom); yr = 8'($urandom);
        x_position = xr; y_position = yr;
        expect_frame(xr, yr);
        expect_frame(xr, yr);
        n0 = rise_q.size();
        pulse_req();
        n = 0;
        while (mon_nb != 2 && n < 1000) begin
            @(negedge clk50mhz);
            n++;
        end
        check("t2_reach_byte2", mon_nb, 2);
        pulse_req();
        repeat (30) @(posedge clk50mhz);
        pulse_req();
        wait_busy(0, 1000, "t2_first_fall");
        wait_busy(1, 10, "t2_second_rise");
        wait_busy(0, 1000, "t2_second_fall");
        repeat (500) @(posedge clk50mhz);
        check("t2_frame_count", rise_q.size() - n0, 2);

        // 3: input change after LOAD does not disturb the frame
        yr = 8'($urandom);
        x_position = 8'h10; y_position = yr;
        expect_frame(8'h10, yr);
        pulse_req();
        wait_busy(1, 10, "t3_rise");
        @(posedge clk50mhz);
        #1 x_position = 8'hF0;
        wait_busy(0, 1000, "t3_fall");

        // 4: periodic reporting
        xr = 8'($urandom); yr = 8'($urandom);
        x_position = xr; y_position = yr;
        n0 = rise_q.size();
        repeat (3) expect_frame(xr, yr);
        @(posedge clk50mhz);
        #1 report_en = 1'b1;
        en_cyc = cyc;
        repeat (3500) @(posedge clk50mhz);
        #1 report_en = 1'b0;
        check("t4_frames", rise_q.size() - n0, 3);
        for (int k = 0; k < 3; k++) begin
            if (rise_q.size() > n0 + k)
                check("t4_start_time", rise_q[n0+k] - en_cyc, REPORT_PERIOD * (k + 1));
        end
        repeat (1500) @(posedge clk50mhz);
        check("t4_disabled_no_frame", rise_q.size() - n0, 3);
        expect_frame(xr, yr);
        #1 report_en = 1'b1;
        en_cyc = cyc;
        repeat (1200) @(posedge clk50mhz);
        #1 report_en = 1'b0;
        check("t4_reenable_frames", rise_q.size() - n0, 4);
        if (rise_q.size() > n0 + 3)
            check("t4_reenable_time", rise_q[n0+3] - en_cyc, REPORT_PERIOD);
        wait_busy(0, 1000, "t4_fall");

        // 5: reset during byte 1 data bits aborts the frame
        x_position = 8'($urandom); y_position = 8'($urandom);
        pulse_req();
        n = 0;
        while (mon_nb != 1 && n < 1000) begin
            @(negedge clk50mhz);
            n++;
        end
        repeat (2 * TICK) @(posedge clk50mhz);
        fd0 = fd_total;
        #1 rst_n = 1'b0;
        @(posedge clk50mhz);
        #1;
        check("t5_reset_tx", uart_tx, 1);
        check("t5_reset_busy", busy, 0);
        repeat (2) @(posedge clk50mhz);
        #1 rst_n = 1'b1;
        lows = 0;
        repeat (200) begin
            @(negedge clk50mhz);
            if (!uart_tx || busy) lows++;
        end
        check("t5_line_idle", lows, 0);
        check("t5_no_frame_done", fd_total, fd0);

        // 6: request in the frame_done cycle goes through the pending path
        xr = 8'($urandom); yr = 8'($urandom);
        x_position = xr; y_position = yr;
        expect_frame(xr, yr);
        expect_frame(xr, yr);
        n0 = rise_q.size();
        pulse_req();
        n = 0;
        while (!frame_done && n < 1000) begin
            @(negedge clk50mhz);
            n++;
        end
        check("t6_frame_done_seen", frame_done, 1);
        report_req = 1'b1;
        @(posedge clk50mhz);
        #1 report_req = 1'b0;
        wait_busy(0, 10, "t6_fall");
        wait_busy(1, 10, "t6_rise");
        wait_busy(0, 1000, "t6_second_fall");
        check("t6_frames", rise_q.size() - n0, 2);

        // random frames with inputs scrambled while in flight
        repeat (6) begin
            xr = 8'($urandom); yr = 8'($urandom);
            x_position = xr; y_position = yr;
            expect_frame(xr, yr);
            repeat ($urandom_range(0, 15)) @(posedge clk50mhz);
            pulse_req();
            wait_busy(1, 10, "rnd_rise");
            @(posedge clk50mhz);
            #1;
            n = 0;
            while (busy && n < 1000) begin
                x_position = 8'($urandom);
                y_position = 8'($urandom);
                @(posedge clk50mhz);
                #1 n++;
            end
            check("rnd_fall", busy, 0);
        end

        repeat (50) @(posedge clk50mhz);
        check("exp_queue_empty", exp_q.size(), 0);
        check("frame_done_total", fd_total, frames_pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
